// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: active-low segment
// patterns ({a,b,c,d,e,f,g}, 0 = lit), symbol codes and the capture FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;   // lowercase b
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;   // lowercase d
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_U     = 7'b1100011;
    localparam logic [6:0] SEG_N     = 7'b1101010;
    localparam logic [6:0] SEG_P     = 7'b0011000;

    localparam logic [4:0] SYM_MINUS   = 5'd16;
    localparam logic [4:0] SYM_BLANK   = 5'd17;
    localparam logic [4:0] SYM_INVALID = 5'd31;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } state_t;

    // True when exactly one digit select is driven low.
    function automatic logic onehot_low(input logic [3:0] an);
        return (an == 4'b0111) || (an == 4'b1011) ||
               (an == 4'b1101) || (an == 4'b1110);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low segment pattern back to a symbol code.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [4:0] code
);

    // Table lookup; letter patterns that alias digits ('O', 's') decode as the digit.
    always_comb begin
        code = SYM_INVALID;
        case (pattern)
            SEG_0:     code = 5'd0;
            SEG_1:     code = 5'd1;
            SEG_2:     code = 5'd2;
            SEG_3:     code = 5'd3;
            SEG_4:     code = 5'd4;
            SEG_5:     code = 5'd5;
            SEG_6:     code = 5'd6;
            SEG_7:     code = 5'd7;
            SEG_8:     code = 5'd8;
            SEG_9:     code = 5'd9;
            SEG_A:     code = 5'd10;
            SEG_B:     code = 5'd11;
            SEG_C:     code = 5'd12;
            SEG_D:     code = 5'd13;
            SEG_E:     code = 5'd14;
            SEG_F:     code = 5'd15;
            SEG_MINUS: code = SYM_MINUS;
            SEG_BLANK: code = SYM_BLANK;
            default:   code = SYM_INVALID;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of the 4-digit multiplexed seven-segment scan: debounces each
// digit dwell, decodes it, and assembles complete 4-digit frames.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  anodes,
    input  logic [6:0]  cathodes,
    input  logic        err_clr,
    output logic        frame_valid,
    output logic [19:0] frame_digits,
    output logic        anode_err,
    output logic        stale
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    state_t        state, state_next;
    logic [3:0]    an_q, an_p;
    logic [6:0]    ca_q, ca_p;
    logic [SW-1:0] settle_cnt, settle_next;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    mask, mask_merged;
    logic [4:0]    slots [4];
    logic [4:0]    slots_merged [4];
    logic [4:0]    dec_code;
    logic [1:0]    slot_idx;
    logic          pair_change, capture, err_set, frame_done, timeout_hit;

    seg7_pattern_decode u_decode (
        .pattern (ca_q),
        .code    (dec_code)
    );

    assign pair_change = {an_q, ca_q} != {an_p, ca_p};

    // Digit select to slot number (digit 3 is the leftmost anode).
    always_comb begin
        slot_idx = 2'd0;
        case (an_q)
            4'b0111: slot_idx = 2'd3;
            4'b1011: slot_idx = 2'd2;
            4'b1101: slot_idx = 2'd1;
            default: slot_idx = 2'd0;
        endcase
    end

    // Dwell debounce FSM: next state, settle count and sample decisions.
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        capture     = 1'b0;
        err_set     = 1'b0;
        case (state)
            ST_WAIT: begin
                if (pair_change) begin
                    state_next  = ST_SETTLE;
                    settle_next = '0;
                end
            end
            ST_SETTLE: begin
                if (pair_change) begin
                    settle_next = '0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    if (an_q == 4'b1111) begin
                        state_next = ST_WAIT;
                    end else if (onehot_low(an_q)) begin
                        capture    = 1'b1;
                        state_next = ST_HELD;
                    end else begin
                        err_set    = 1'b1;
                        state_next = ST_HELD;
                    end
                end else begin
                    settle_next = settle_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (pair_change) begin
                    state_next  = ST_SETTLE;
                    settle_next = '0;
                end
            end
            default: state_next = ST_WAIT;
        endcase
    end

    // Slot/mask view including this cycle's capture, so a completing frame is emitted one cycle after it.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            slots_merged[i] = slots[i];
        end
        mask_merged = mask;
        if (capture) begin
            slots_merged[slot_idx] = dec_code;
            mask_merged            = mask | (4'b0001 << slot_idx);
        end
        frame_done  = capture && (mask_merged == 4'b1111);
        timeout_hit = !capture && (tmo_cnt == TIMEOUT_MAX - 1'b1);
    end

    // Input registers, FSM state, counters, slots, frame output and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q         <= '1;
            an_p         <= '1;
            ca_q         <= '1;
            ca_p         <= '1;
            state        <= ST_WAIT;
            settle_cnt   <= '0;
            tmo_cnt      <= '0;
            mask         <= '0;
            slots        <= '{default: '0};
            frame_valid  <= 1'b0;
            frame_digits <= '0;
            anode_err    <= 1'b0;
            stale        <= 1'b0;
        end else begin
            an_q       <= anodes;
            ca_q       <= cathodes;
            an_p       <= an_q;
            ca_p       <= ca_q;
            state      <= state_next;
            settle_cnt <= settle_next;
            slots      <= slots_merged;

            if (capture) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TIMEOUT_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            frame_valid <= frame_done;
            if (frame_done) begin
                frame_digits <= {slots_merged[3], slots_merged[2],
                                 slots_merged[1], slots_merged[0]};
            end

            if (frame_done || timeout_hit) begin
                mask <= '0;
            end else begin
                mask <= mask_merged;
            end

            anode_err <= err_set     | (anode_err & ~err_clr);
            stale     <= timeout_hit | (stale & ~err_clr);
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: stimulus pushes expected frames,
// a monitor pops and compares on every frame_valid pulse.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  anodes;
    logic [6:0]  cathodes;
    logic        err_clr;
    logic        frame_valid;
    logic [19:0] frame_digits;
    logic        anode_err;
    logic        stale;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [19:0] exp_q [$];

    localparam logic [6:0] P0   = 7'b0000001;
    localparam logic [6:0] P1   = 7'b1001111;
    localparam logic [6:0] P2   = 7'b0010010;
    localparam logic [6:0] P3   = 7'b0000110;
    localparam logic [6:0] P4   = 7'b1001100;
    localparam logic [6:0] P5   = 7'b0100100;
    localparam logic [6:0] P6   = 7'b0100000;
    localparam logic [6:0] P7   = 7'b0001111;
    localparam logic [6:0] P8   = 7'b0000000;
    localparam logic [6:0] P9   = 7'b0000100;
    localparam logic [6:0] PE   = 7'b0110000;
    localparam logic [6:0] PF   = 7'b0111000;
    localparam logic [6:0] PMIN = 7'b1111110;
    localparam logic [6:0] PBLK = 7'b1111111;

    seg7_scan_capture #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .anodes       (anodes),
        .cathodes     (cathodes),
        .err_clr      (err_clr),
        .frame_valid  (frame_valid),
        .frame_digits (frame_digits),
        .anode_err    (anode_err),
        .stale        (stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] ca, input int unsigned n);
        anodes   = an;
        cathodes = ca;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input logic [3:0] an, input logic [6:0] ca);
        show(an, ca, 10);
        show(4'b1111, PBLK, 4);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        check("frame_arrived", exp_q.size(), 0);
    endtask

    // Monitor: every frame_valid must match the oldest expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame actual=%h required=none", frame_digits);
                end else begin
                    check("frame_digits", frame_digits, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        err_clr  = 1'b0;
        anodes   = 4'b1111;
        cathodes = PBLK;
        repeat (3) @(negedge clk);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_frame_digits", frame_digits, 0);
        check("rst_anode_err", anode_err, 0);
        check("rst_stale", stale, 0);
        rst_n = 1'b1;
        show(4'b1111, PBLK, 4);

        // 1: basic scan 1,2,3,4
        exp_q.push_back({5'd1, 5'd2, 5'd3, 5'd4});
        digit(4'b0111, P1);
        digit(4'b1011, P2);
        digit(4'b1101, P3);
        digit(4'b1110, P4);
        drain();
        check("t1_stale", stale, 0);

        // 2: 3-cycle dwells never settle; timeout raises stale
        for (int r = 0; r < 8; r++) begin
            show(4'b0111, P5, 3);
            show(4'b1011, P6, 3);
            show(4'b1101, P7, 3);
            show(4'b1110, P8, 3);
        end
        show(4'b1111, PBLK, 4);
        check("t2_stale", stale, 1);
        check("t2_anode_err", anode_err, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("t2_stale_cleared", stale, 0);

        // 3: multiple anodes low -> error, mask keeps d3
        exp_q.push_back({5'd1, 5'd7, 5'd8, 5'd9});
        digit(4'b0111, P1);
        show(4'b0011, P5, 8);
        show(4'b1111, PBLK, 4);
        check("t3_anode_err", anode_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("t3_anode_err_cleared", anode_err, 0);
        digit(4'b1011, P7);
        digit(4'b1101, P8);
        digit(4'b1110, P9);
        drain();

        // 4: digit 0 changes mid-dwell, latest capture wins
        exp_q.push_back({5'd5, 5'd6, 5'd7, 5'd1});
        show(4'b1110, P0, 10);
        digit(4'b1110, P1);
        digit(4'b0111, P5);
        digit(4'b1011, P6);
        digit(4'b1101, P7);
        drain();

        // 5: partial frame dropped on timeout, then F,E,minus,blank
        check("t5_stale_before", stale, 0);
        digit(4'b0111, P2);
        digit(4'b1011, P3);
        digit(4'b1101, P4);
        show(4'b1111, PBLK, 75);
        check("t5_stale", stale, 1);
        exp_q.push_back({5'd15, 5'd14, 5'd16, 5'd17});
        digit(4'b0111, PF);
        digit(4'b1011, PE);
        digit(4'b1101, PMIN);
        digit(4'b1110, PBLK);
        drain();

        // 6: reset after three captures discards the partial frame
        digit(4'b0111, P1);
        digit(4'b1011, P2);
        show(4'b1101, P3, 10);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_frame_valid", frame_valid, 0);
        check("t6_frame_digits", frame_digits, 0);
        check("t6_anode_err", anode_err, 0);
        check("t6_stale", stale, 0);
        rst_n = 1'b1;
        show(4'b1111, PBLK, 4);
        digit(4'b1110, P4);
        show(4'b1111, PBLK, 10);
        check("t6_frame_digits_after", frame_digits, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
